// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: data width, receive FIFO depth and the stored entry layout.
package uart_defs;

    localparam int unsigned UART_DATA_SIZE     = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH = 8;

    typedef struct packed {
        logic                      ferr;
        logic [UART_DATA_SIZE-1:0] data;
    } type_uart_rx_entry_s;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side push, register-block pop and status signals of the UART receive FIFO.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
);
    logic [DATA_W-1:0] rx_data_i;
    logic              rx_valid_i;
    logic              rx_ferr_i;
    logic              rx_en_i;
    logic              flush_i;
    logic              rd_en_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_ferr_o;
    logic              empty_o;
    logic              full_o;
    logic [CNT_W-1:0]  count_o;
    logic              overrun_o;
    logic [CNT_W-1:0]  watermark_i;
    logic              irq_o;

    modport master (
        output rx_data_i, rx_valid_i, rx_ferr_i, rx_en_i, flush_i, rd_en_i, watermark_i,
        input  rd_data_o, rd_ferr_o, empty_o, full_o, count_o, overrun_o, irq_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, rx_ferr_i, rx_en_i, flush_i, rd_en_i, watermark_i,
        output rd_data_o, rd_ferr_o, empty_o, full_o, count_o, overrun_o, irq_o
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// Unreset entry storage: one synchronous write port, one combinational read port.
module uart_fifo_mem
    import uart_defs::*;
#(
    parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [PTR_W-1:0]    waddr,
    input  type_uart_rx_entry_s wdata,
    input  logic [PTR_W-1:0]    raddr,
    output type_uart_rx_entry_s rdata
);

    type_uart_rx_entry_s mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive buffer with occupancy count, sticky overrun flag and watermark interrupt.
module uart_rx_fifo
    import uart_defs::*;
#(
    parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int unsigned DATA_W = UART_DATA_SIZE,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                overrun_q;
    logic                empty, full;
    logic                push_req, push, pop, drop;
    type_uart_rx_entry_s wr_entry, rd_entry;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    assign push_req = bus.rx_valid_i & bus.rx_en_i & ~bus.flush_i;
    assign pop      = bus.rd_en_i & ~empty & ~bus.flush_i;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign wr_entry.ferr = bus.rx_ferr_i;
    assign wr_entry.data = bus.rx_data_i;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.rd_data_o = empty ? '0 : rd_entry.data[DATA_W-1:0];
    assign bus.rd_ferr_o = empty ? 1'b0 : rd_entry.ferr;
    assign bus.empty_o   = empty;
    assign bus.full_o    = full;
    assign bus.count_o   = count_q;
    assign bus.overrun_o = overrun_q;
    assign bus.irq_o     = (count_q > bus.watermark_i);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model plus a decoupled pop monitor.
module tb_uart_rx_fifo;
    import uart_defs::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(8), .CNT_W(CW)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [8:0] mq[$];   // model contents {ferr, data}, head at index 0
    logic [8:0] sb[$];   // expected popped entries
    bit         movr;
    int         nchecks = 0;
    int         npass   = 0;

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act == exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_status();
        int n;
        n = mq.size();
        check("count", int'(bus.count_o), n);
        check("empty", int'(bus.empty_o), int'(n == 0));
        check("full", int'(bus.full_o), int'(n == DEPTH));
        check("overrun", int'(bus.overrun_o), int'(movr));
        check("irq", int'(bus.irq_o), int'(n > int'(bus.watermark_i)));
        check("rd_data", int'(bus.rd_data_o), (n > 0) ? int'(mq[0][7:0]) : 0);
        check("rd_ferr", int'(bus.rd_ferr_o), (n > 0) ? int'(mq[0][8]) : 0);
    endtask

    // Called just after a rising edge; drives one cycle of inputs and advances the model.
    task automatic step(input bit v, input logic [7:0] d, input bit f, input bit en,
                        input bit fl, input bit rd);
        bit do_pop;
        bus.rx_valid_i = v;
        bus.rx_data_i  = d;
        bus.rx_ferr_i  = f;
        bus.rx_en_i    = en;
        bus.flush_i    = fl;
        bus.rd_en_i    = rd;
        if (fl) begin
            mq.delete();
            movr = 1'b0;
        end else begin
            do_pop = rd && (mq.size() > 0);
            if (do_pop) sb.push_back(mq.pop_front());
            if (v && en) begin
                if (mq.size() < DEPTH) mq.push_back({f, d});
                else movr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    // Reset with random in-flight traffic that must be discarded.
    task automatic do_reset();
        rst            = 1'b1;
        bus.rx_valid_i = 1'($urandom);
        bus.rx_data_i  = 8'($urandom);
        bus.rx_en_i    = 1'b1;
        bus.rd_en_i    = 1'($urandom);
        bus.flush_i    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        movr = 1'b0;
        check_status();
    endtask

    // Monitor: every accepted pop must present the next expected entry.
    always @(negedge clk) begin
        if (!rst && bus.rd_en_i && !bus.empty_o && !bus.flush_i) begin
            if (sb.size() == 0) check("pop_unexpected", 1, 0);
            else check("pop_data", int'({bus.rd_ferr_o, bus.rd_data_o}), int'(sb.pop_front()));
        end
    end

    initial begin
        bus.rx_valid_i  = 1'b0;
        bus.rx_data_i   = '0;
        bus.rx_ferr_i   = 1'b0;
        bus.rx_en_i     = 1'b1;
        bus.flush_i     = 1'b0;
        bus.rd_en_i     = 1'b0;
        bus.watermark_i = CW'(DEPTH);
        movr            = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        push(8'h41); push(8'h42); push(8'h43);
        repeat (3) pop1();
        check("drained_after_3", sb.size(), 0);

        for (int i = 0; i < 8; i++) push(8'(i));
        push(8'hAA);
        repeat (8) pop1();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (8) pop1();

        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1, 1'b0, i >= 2);
        repeat (3) pop1();

        step(1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        pop1();

        bus.watermark_i = CW'(2);
        push(8'h01); push(8'h02); push(8'h03);
        step(1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0);

        push(8'h21); push(8'h22);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) bus.watermark_i = CW'($urandom_range(0, DEPTH + 1));
            if ($urandom_range(0, 299) == 0) do_reset();
            else step($urandom_range(0, 2) != 0, 8'($urandom), 1'($urandom),
                      $urandom_range(0, 7) != 0, $urandom_range(0, 60) == 0,
                      $urandom_range(0, 2) == 0);
        end

        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer between the UART bit-level receiver and the UART register/Dbus block.
- Captures each byte the receiver reports valid (with its frame-error tag) into a first-word-fall-through FIFO.
- Register block pops entries on RXDATA reads.
- Provides occupancy, an overrun flag and a watermark interrupt.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- DATA_W, 8, byte width; equals UART_DATA_SIZE.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count and watermark.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- rx_data_i  input  DATA_W  byte from receiver.
- rx_valid_i  input  1  one-cycle push strobe from receiver.
- rx_ferr_i  input  1  frame error for the byte presented with rx_valid_i.
- rx_en_i  input  1  receive enable; when 0, pushes are discarded.
- flush_i  input  1  one-cycle: empty the FIFO and clear overrun.
- rd_en_i  input  1  one-cycle pop strobe from register block.
- rd_data_o  output  DATA_W  head-entry byte.
- rd_ferr_o  output  1  head-entry frame-error tag.
- empty_o  output  1  FIFO empty.
- full_o  output  1  FIFO full.
- count_o  output  CNT_W  current occupancy, 0..DEPTH.
- overrun_o  output  1  sticky: a byte was dropped because the FIFO was full.
- watermark_i  input  CNT_W  interrupt threshold.
- irq_o  output  1  level: count_o > watermark_i.

Behaviour:
- Reset, synchronous on rst=1 at clk edge:
  - Pointers, count and overrun are cleared.
  - Outputs: empty_o=1, full_o=0, count_o=0, overrun_o=0, irq_o=0, rd_data_o=0, rd_ferr_o=0.
  - Memory contents are not reset, but rd_data_o/rd_ferr_o are forced to 0 while empty_o=1.
- Storage: DEPTH entries of {ferr, data}. Write and read pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. A separate count register holds occupancy.
- Push condition: rx_valid_i & rx_en_i & ~flush_i.
  - Accepted if not full, or if full with a simultaneous valid pop.
  - Entry is written at wr_ptr; wr_ptr increments.
- Pop condition: rd_en_i & ~empty_o & ~flush_i. rd_ptr increments.
- Pop on empty is ignored: no pointer change, no error flag.
- Push and pop in the same cycle:
  - count unchanged, both pointers advance.
  - When empty, only the push takes effect.
  - When full, both take effect and no overrun.
- Overrun: push while full without a pop drops the byte. Pointers and count are unchanged; overrun_o is set next cycle and holds until flush_i or rst.
- rx_valid_i with rx_en_i=0: ignored entirely and never sets overrun.
- Flush has priority over push and pop in the same cycle. Next cycle: count=0, pointers equal, overrun_o=0.
- Latency (FWFT):
  - Byte pushed at edge N is visible on rd_data_o/rd_ferr_o, with empty_o=0 and count_o updated, after edge N.
  - A pop at edge N exposes the next entry after edge N.
- Status outputs: empty_o=(count==0), full_o=(count==DEPTH), derived from registered count only; no combinational path from any input.
- irq_o = (count_o > watermark_i); combinational on watermark_i, registered on count. With watermark_i >= DEPTH, irq_o is never asserted.
- rx_ferr_i is stored per entry. It does not affect acceptance; errored bytes are buffered like any other.
- Reset mid-stream: any in-flight push or pop on the reset edge is discarded.

Decomposition:
- uart_defs package holds:
  - UART_DATA_SIZE
  - UART_RX_FIFO_DEPTH, default for DEPTH
  - typedef struct packed type_uart_rx_entry_s {logic ferr; logic [UART_DATA_SIZE-1:0] data;}
- Sub-module uart_fifo_mem: DEPTH x entry register array, one synchronous write port, one combinational read port, no reset.
- Pointer, count, flag and interrupt logic stay in uart_rx_fifo.

Test Plan:
- Reset then push 0x41, 0x42, 0x43 on consecutive cycles:
  - count_o=3, empty_o=0, rd_data_o=0x41.
  - Three pops return 0x41, 0x42, 0x43 in order.
  - empty_o=1 and rd_data_o=0 afterwards.
- Push 8 bytes 0x00..0x07 (DEPTH=8): full_o=1. Push 0xAA: overrun_o=1, count_o=8, and pops return 0x00..0x07 with no 0xAA. flush_i then clears overrun_o.
- Full FIFO, same-cycle push 0x55 and pop: overrun_o stays 0, count_o=8, and the last of the remaining 8 pops returns 0x55.
- Pointer wrap: repeated push/pop of 20 bytes 0x10..0x23 with occupancy kept ≤3 returns data in order, crossing the pointer wrap at least twice.
- Push with rx_ferr_i=1 (byte 0x7E), then rx_en_i=0 with push 0x11:
  - rd_ferr_o=1 with rd_data_o=0x7E; count_o=1.
  - The 0x11 push is discarded: count_o stays 1, overrun_o stays 0.
- watermark_i=2: irq_o=0 at count 1–2 and 1 at count 3. Flush asserted in the same cycle as a push: next cycle count_o=0 and irq_o=0.
